// File: rtl/lab_pkg.sv
// Shared types and constants for the drawing lab: VGA geometry, engine FSM states
// and the pixel record carried from the engines to the VGA adapter.
package lab_pkg;

  localparam int VGA_W       = 160;
  localparam int VGA_H       = 120;
  localparam int FILL_CYCLES = VGA_W * VGA_H;

  typedef enum logic [1:0] {
    FSM_IDLE,
    FSM_BUSY,
    FSM_DONE
  } e_FSM_state;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    RUN,
    RELEASE,
    FIN
  } e_seq_state;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

endpackage

// File: rtl/draw_sequencer_plot_mux.sv
// Registered pixel selector: forwards the selected engine's pixel to the VGA adapter
// one cycle later, gating plot outside the active window and holding x/y/colour.
module plot_mux
  import lab_pkg::*;
#(
  parameter int N_ENG = 2,
  parameter int CUR_W = $clog2(N_ENG) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               active,
  input  logic [CUR_W-1:0]   sel,
  input  logic [8*N_ENG-1:0] eng_x,
  input  logic [7*N_ENG-1:0] eng_y,
  input  logic [3*N_ENG-1:0] eng_vcol,
  input  logic [N_ENG-1:0]   eng_plot,
  output logic [7:0]         vga_x,
  output logic [6:0]         vga_y,
  output logic [2:0]         vga_colour,
  output logic               vga_plot
);

  pixel_t pix_q, pix_d;
  logic   plot_q, plot_d;

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    pix_d  = pix_q;
    plot_d = 1'b0;
    if (active) begin
      for (int i = 0; i < N_ENG; i++) begin
        if (sel == CUR_W'(i)) begin
          pix_d.x      = eng_x[8*i +: 8];
          pix_d.y      = eng_y[7*i +: 7];
          pix_d.colour = eng_vcol[3*i +: 3];
          plot_d       = eng_plot[i];
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous, sampled on clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q  <= '0;
      plot_q <= 1'b0;
    end else begin
      pix_q  <= pix_d;
      plot_q <= plot_d;
    end
  end

  assign vga_x      = pix_q.x;
  assign vga_y      = pix_q.y;
  assign vga_colour = pix_q.colour;
  assign vga_plot   = plot_q;

endmodule

// File: rtl/draw_sequencer.sv
// Runs each enabled drawing engine in ascending slot order over the single VGA plot
// port, programming its colour and aborting any engine that holds start too long.
module draw_sequencer
  import lab_pkg::*;
#(
  parameter int N_ENG   = 2,
  parameter int TIMEOUT = 65536
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               done,
  input  logic [N_ENG-1:0]   eng_en,
  input  logic [3*N_ENG-1:0] colour_cfg,
  output logic [N_ENG-1:0]   eng_start,
  output logic [3*N_ENG-1:0] eng_colour,
  input  logic [N_ENG-1:0]   eng_done,
  input  logic [8*N_ENG-1:0] eng_x,
  input  logic [7*N_ENG-1:0] eng_y,
  input  logic [3*N_ENG-1:0] eng_vcol,
  input  logic [N_ENG-1:0]   eng_plot,
  output logic [7:0]         vga_x,
  output logic [6:0]         vga_y,
  output logic [2:0]         vga_colour,
  output logic               vga_plot,
  output logic [N_ENG-1:0]   err
);

  // One extra cur bit lets SCAN see that it has walked past the last slot.
  localparam int              CUR_W   = $clog2(N_ENG) + 1;
  localparam int              WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  e_seq_state         state_q, state_d;
  logic [CUR_W-1:0]   cur_q, cur_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [N_ENG-1:0]   en_q, en_d;
  logic [3*N_ENG-1:0] col_q, col_d;
  logic [N_ENG-1:0]   err_q, err_d;
  logic               to_q, to_d;

  logic [N_ENG-1:0]   cur_oh;
  logic               cur_done;
  logic               scan_hit;
  logic [CUR_W-1:0]   scan_idx;

  always_comb begin
    cur_oh = '0;
    for (int i = 0; i < N_ENG; i++) begin
      cur_oh[i] = (cur_q == CUR_W'(i));
    end
  end

  // Done from any slot other than the current one is ignored.
  assign cur_done = |(eng_done & cur_oh);

  // Descending walk so the lowest enabled slot at or above cur wins.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int i = N_ENG - 1; i >= 0; i--) begin
      if (en_q[i] && (CUR_W'(i) >= cur_q)) begin
        scan_hit = 1'b1;
        scan_idx = CUR_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      wd_q    <= '0;
      en_q    <= '0;
      col_q   <= '0;
      err_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      wd_q    <= wd_d;
      en_q    <= en_d;
      col_q   <= col_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    wd_d    = wd_q;
    en_d    = en_q;
    col_d   = col_q;
    err_d   = err_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          en_d    = eng_en;
          col_d   = colour_cfg;
          err_d   = '0;
          cur_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        wd_d = '0;
        to_d = 1'b0;
        if (scan_hit) begin
          cur_d   = scan_idx;
          state_d = RUN;
        end else begin
          state_d = FIN;
        end
      end
      RUN: begin
        wd_d = wd_q + 1'b1;
        if (cur_done) begin
          state_d = RELEASE;
        end else if (wd_q == WD_LAST) begin
          err_d   = err_q | cur_oh;
          to_d    = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // A hung engine may never drop done, so an aborted slot leaves at once.
        if (to_q || !cur_done) begin
          cur_d   = cur_q + 1'b1;
          state_d = SCAN;
        end
      end
      FIN: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    eng_start = '0;
    done      = 1'b0;
    if (state_q == RUN) eng_start = cur_oh;
    if (state_q == FIN) done = 1'b1;
  end

  assign eng_colour = col_q;
  assign err        = err_q;

  plot_mux #(
    .N_ENG (N_ENG),
    .CUR_W (CUR_W)
  ) u_plot_mux (
    .clk        (clk),
    .rst        (rst),
    .active     (state_q == RUN),
    .sel        (cur_q),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_vcol   (eng_vcol),
    .eng_plot   (eng_plot),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: two instances (long and short watchdog) driven by
// behavioural engines, with an expected-pixel queue built from the enable mask and colours.
`timescale 1ns/1ps
module tb_draw_sequencer;
  import lab_pkg::*;

  localparam int N  = 2;
  localparam int CW = 3 * N;
  localparam int MODE_PLOT = 0;
  localparam int MODE_HANG = 1;
  localparam int FILL_LEN  = 19200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_w        [2];
  logic          start_w      [2];
  logic          done_w       [2];
  logic [N-1:0]  en_w         [2];
  logic [CW-1:0] cfg_w        [2];
  logic [N-1:0]  eng_start_w  [2];
  logic [CW-1:0] eng_colour_w [2];
  logic [N-1:0]  eng_done_w   [2];
  logic [8*N-1:0] eng_x_w     [2];
  logic [7*N-1:0] eng_y_w     [2];
  logic [CW-1:0] eng_vcol_w   [2];
  logic [N-1:0]  eng_plot_w   [2];
  logic [7:0]    vga_x_w      [2];
  logic [6:0]    vga_y_w      [2];
  logic [2:0]    vga_colour_w [2];
  logic          vga_plot_w   [2];
  logic [N-1:0]  err_w        [2];

  draw_sequencer #(.N_ENG(N), .TIMEOUT(65536)) dut_a (
    .clk(clk), .rst(rst_w[0]), .start(start_w[0]), .done(done_w[0]),
    .eng_en(en_w[0]), .colour_cfg(cfg_w[0]), .eng_start(eng_start_w[0]),
    .eng_colour(eng_colour_w[0]), .eng_done(eng_done_w[0]), .eng_x(eng_x_w[0]),
    .eng_y(eng_y_w[0]), .eng_vcol(eng_vcol_w[0]), .eng_plot(eng_plot_w[0]),
    .vga_x(vga_x_w[0]), .vga_y(vga_y_w[0]), .vga_colour(vga_colour_w[0]),
    .vga_plot(vga_plot_w[0]), .err(err_w[0]));

  draw_sequencer #(.N_ENG(N), .TIMEOUT(100)) dut_b (
    .clk(clk), .rst(rst_w[1]), .start(start_w[1]), .done(done_w[1]),
    .eng_en(en_w[1]), .colour_cfg(cfg_w[1]), .eng_start(eng_start_w[1]),
    .eng_colour(eng_colour_w[1]), .eng_done(eng_done_w[1]), .eng_x(eng_x_w[1]),
    .eng_y(eng_y_w[1]), .eng_vcol(eng_vcol_w[1]), .eng_plot(eng_plot_w[1]),
    .vga_x(vga_x_w[1]), .vga_y(vga_y_w[1]), .vga_colour(vga_colour_w[1]),
    .vga_plot(vga_plot_w[1]), .err(err_w[1]));

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } exp_pix_t;

  exp_pix_t exp_q [$];
  int   eng_mode     [2][N];
  int   eng_len      [2][N];
  int   e_cnt        [2][N];
  logic e_done       [2][N];
  int   start_cycles [2][N];
  logic prev_plot    [2];
  logic rst_last     [2];
  int   plot_pulses;
  int   checks;
  int   failures;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected pixel stream: each enabled non-hung slot in ascending order, pixel k at
  // (k mod 160, k div 160) in the colour configured at start.
  function automatic void push_run(input int d, input logic [N-1:0] en, input logic [CW-1:0] cfg);
    exp_pix_t p;
    for (int i = 0; i < N; i++) begin
      if (en[i] && eng_mode[d][i] == MODE_PLOT) begin
        for (int k = 0; k < eng_len[d][i]; k++) begin
          p.x = 8'(k % VGA_W);
          p.y = 7'(k / VGA_W);
          p.c = cfg[3*i +: 3];
          exp_q.push_back(p);
        end
      end
    end
  endfunction

  // Compare process plus engine models; engines react on the falling edge.
  task automatic monitor();
    exp_pix_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check("vga_plot_latency", vga_plot_w[d], prev_plot[d] & ~rst_last[d]);
        if (!rst_last[d]) check("eng_start_onehot", $countones(eng_start_w[d]) <= 1, 1);
        for (int i = 0; i < N; i++) if (eng_start_w[d][i] === 1'b1) start_cycles[d][i]++;
        if (vga_plot_w[d] === 1'b1) begin
          plot_pulses++;
          check("pixel_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("vga_x", vga_x_w[d], e.x);
            check("vga_y", vga_y_w[d], e.y);
            check("vga_colour", vga_colour_w[d], e.c);
          end
        end
      end
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < N; i++) begin
          eng_plot_w[d][i] = 1'b0;
          if (eng_start_w[d][i] !== 1'b1) begin
            e_cnt[d][i]  = 0;
            e_done[d][i] = 1'b0;
          end else if (!e_done[d][i] && eng_mode[d][i] == MODE_PLOT) begin
            if (e_cnt[d][i] < eng_len[d][i]) begin
              eng_plot_w[d][i]       = 1'b1;
              eng_x_w[d][8*i +: 8]   = 8'(e_cnt[d][i] % VGA_W);
              eng_y_w[d][7*i +: 7]   = 7'(e_cnt[d][i] / VGA_W);
              eng_vcol_w[d][3*i +: 3] = eng_colour_w[d][3*i +: 3];
              e_cnt[d][i]++;
            end else begin
              e_done[d][i] = 1'b1;
            end
          end
          eng_done_w[d][i] = e_done[d][i];
        end
        prev_plot[d] = |eng_plot_w[d];
        rst_last[d]  = rst_w[d];
      end
    end
  endtask

  task automatic run_seq(input int d, input logic [N-1:0] en, input logic [CW-1:0] cfg,
                         input bit scramble, input bit drop_early, input int budget,
                         output int first_start, output int done_n);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    first_start = -1;
    done_n = -1;
    push_run(d, en, cfg);
    for (int i = 0; i < N; i++) start_cycles[d][i] = 0;
    en_w[d]    = en;
    cfg_w[d]   = cfg;
    start_w[d] = 1'b1;
    while (!seen && n < budget) begin
      tick();
      n++;
      if (first_start < 0 && eng_start_w[d] != '0) first_start = n;
      if (done_w[d] === 1'b1) begin
        seen = 1'b1;
        done_n = n;
      end
      if (scramble) begin
        en_w[d]  = N'($urandom);
        cfg_w[d] = CW'($urandom);
      end
      if (drop_early && n == 3) start_w[d] = 1'b0;
    end
    check("done_reached", seen, 1);
  endtask

  task automatic finish_seq(input int d);
    start_w[d] = 1'b0;
    tick();
    check("done_falls", done_w[d], 0);
  endtask

  task automatic check_reset_outputs(input int d);
    check("rst_done", done_w[d], 0);
    check("rst_eng_start", eng_start_w[d], 0);
    check("rst_vga_x", vga_x_w[d], 0);
    check("rst_vga_y", vga_y_w[d], 0);
    check("rst_vga_colour", vga_colour_w[d], 0);
    check("rst_vga_plot", vga_plot_w[d], 0);
    check("rst_err", err_w[d], 0);
    check("rst_eng_colour", eng_colour_w[d], 0);
  endtask

  initial begin
    int fs, dn, p0, len, n;
    logic [N-1:0]  en;
    logic [CW-1:0] cfg;
    logic [N-1:0]  hang;
    int exp_pulses;

    checks = 0;
    failures = 0;
    plot_pulses = 0;
    for (int d = 0; d < 2; d++) begin
      rst_w[d] = 1'b1; start_w[d] = 1'b0; en_w[d] = '0; cfg_w[d] = '0;
      eng_done_w[d] = '0; eng_x_w[d] = '0; eng_y_w[d] = '0; eng_vcol_w[d] = '0; eng_plot_w[d] = '0;
      prev_plot[d] = 1'b0; rst_last[d] = 1'b1;
      for (int i = 0; i < N; i++) begin
        eng_mode[d][i] = MODE_PLOT; eng_len[d][i] = 10;
        e_cnt[d][i] = 0; e_done[d][i] = 1'b0; start_cycles[d][i] = 0;
      end
    end
    fork
      monitor();
      begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "time limit");
      end
    join_none

    repeat (3) tick();
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst_w[0] = 1'b0;
    rst_w[1] = 1'b0;
    tick();

    // Fillscreen then a 10-pixel stub.
    eng_len[0][0] = FILL_LEN;
    eng_len[0][1] = 10;
    p0 = plot_pulses;
    run_seq(0, 2'b11, {3'd4, 3'd0}, 1'b0, 1'b0, 25000, fs, dn);
    check("t1_first_start_edge", fs, 2);
    check("t1_done_edge", dn, 19218);
    check("t1_plot_pulses", plot_pulses - p0, 19210);
    check("t1_queue_empty", exp_q.size(), 0);
    check("t1_start_cycles0", start_cycles[0][0], 19201);
    check("t1_start_cycles1", start_cycles[0][1], 11);
    check("t1_err", err_w[0], 0);
    check("t1_eng_colour", eng_colour_w[0], 6'b100_000);
    finish_seq(0);

    // Slot 0 disabled: only the stub runs.
    len = $urandom_range(1, 20);
    eng_len[0][1] = len;
    cfg = CW'($urandom);
    p0 = plot_pulses;
    run_seq(0, 2'b10, cfg, 1'b1, 1'b0, 200, fs, dn);
    check("t2_done_edge", dn, len + 5);
    check("t2_slot0_unstarted", start_cycles[0][0], 0);
    check("t2_plot_pulses", plot_pulses - p0, len);
    check("t2_queue_empty", exp_q.size(), 0);
    finish_seq(0);

    // Nothing enabled.
    p0 = plot_pulses;
    run_seq(0, 2'b00, 6'b111_111, 1'b0, 1'b0, 10, fs, dn);
    check("t3_done_edge", dn, 2);
    check("t3_no_start", fs, -1);
    check("t3_no_plots", plot_pulses - p0, 0);
    finish_seq(0);

    // Short watchdog: slot 0 hangs, slot 1 runs.
    eng_mode[1][0] = MODE_HANG;
    len = $urandom_range(1, 30);
    eng_len[1][1] = len;
    p0 = plot_pulses;
    run_seq(1, 2'b11, CW'($urandom), 1'b0, 1'b0, 1000, fs, dn);
    check("t4_hang_cycles", start_cycles[1][0], 100);
    check("t4_err", err_w[1], 2'b01);
    check("t4_done_edge", dn, 107 + len);
    check("t4_plot_pulses", plot_pulses - p0, len);
    check("t4_queue_empty", exp_q.size(), 0);
    finish_seq(1);
    check("t4_err_sticky", err_w[1], 2'b01);

    // Reset 5000 cycles into a fill, then a clean rerun.
    cfg = CW'($urandom);
    push_run(0, 2'b01, cfg);
    en_w[0] = 2'b01; cfg_w[0] = cfg; start_w[0] = 1'b1;
    n = 0;
    while (eng_start_w[0][0] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("t5_fill_started", eng_start_w[0][0], 1);
    repeat (5000) tick();
    rst_w[0] = 1'b1;
    start_w[0] = 1'b0;
    tick();
    check_reset_outputs(0);
    rst_w[0] = 1'b0;
    exp_q.delete();
    tick();
    check("t5_idle_after_reset", eng_start_w[0], 0);
    p0 = plot_pulses;
    run_seq(0, 2'b01, cfg, 1'b0, 1'b0, 20000, fs, dn);
    check("t5_rerun_pulses", plot_pulses - p0, FILL_LEN);
    check("t5_queue_empty", exp_q.size(), 0);
    finish_seq(0);

    // Start held past done, then a re-latched colour 7 fill.
    eng_len[0][1] = 5;
    run_seq(0, 2'b10, CW'($urandom), 1'b0, 1'b0, 200, fs, dn);
    for (int c = 0; c < 50; c++) begin
      tick();
      check("t6_done_held", done_w[0], 1);
      check("t6_no_restart", eng_start_w[0], 0);
    end
    finish_seq(0);
    p0 = plot_pulses;
    run_seq(0, 2'b01, {3'd2, 3'd7}, 1'b0, 1'b0, 20000, fs, dn);
    check("t6_pulses", plot_pulses - p0, FILL_LEN);
    check("t6_queue_empty", exp_q.size(), 0);
    check("t6_eng_colour", eng_colour_w[0][2:0], 3'd7);
    finish_seq(0);

    // Randomized runs on the short-watchdog instance.
    for (int it = 0; it < 10; it++) begin
      en = N'($urandom);
      cfg = CW'($urandom);
      hang = '0;
      exp_pulses = 0;
      for (int i = 0; i < N; i++) begin
        eng_mode[1][i] = ($urandom_range(0, 2) == 0) ? MODE_HANG : MODE_PLOT;
        eng_len[1][i] = $urandom_range(1, 30);
        hang[i] = (eng_mode[1][i] == MODE_HANG);
        if (en[i] && !hang[i]) exp_pulses += eng_len[1][i];
      end
      p0 = plot_pulses;
      run_seq(1, en, cfg, 1'b1, 1'($urandom_range(0, 1)), 1000, fs, dn);
      check("rnd_err", err_w[1], en & hang);
      check("rnd_plot_pulses", plot_pulses - p0, exp_pulses);
      check("rnd_queue_empty", exp_q.size(), 0);
      for (int i = 0; i < N; i++) begin
        check("rnd_start_cycles", start_cycles[1][i],
              !en[i] ? 0 : (hang[i] ? 100 : eng_len[1][i] + 1));
      end
      finish_seq(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
